// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: 7-digit BCD time
// (mm:ss.mmm), per-digit maxima and a digit clamp helper.
package stopwatch_pkg;

    localparam int DIGN = 7;

    // Packed 7 x 4-bit BCD time, digit 0 = millisecond units.
    typedef logic [DIGN-1:0][3:0] bcd_time_t;

    // Per-digit maximum, index 0 = ms units ... index 6 = tens of minutes.
    localparam bcd_time_t DIG_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9, 4'd9};

    // Saturate every digit at its maximum so a loaded value is always legal.
    function automatic bcd_time_t bcd_clamp(input bcd_time_t t);
        bcd_time_t r;
        for (int i = 0; i < DIGN; i++) begin
            r[i] = (t[i] > DIG_MAX[i]) ? DIG_MAX[i] : t[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch counter chain: up/down by one with
// wrap at MAX, synchronous load, carry (up) / borrow (down) to the next digit.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       dir_i,
    input  logic       load_i,
    input  logic [3:0] ld_val_i,
    output logic [3:0] q_o,
    output logic       co_o
);

    logic [3:0] q_q, q_d;

    assign q_o  = q_q;
    assign co_o = en_i & (dir_i ? (q_q == 4'd0) : (q_q == MAX));

    // Next digit value: load has priority over counting.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = ld_val_i;
        end else if (en_i) begin
            if (dir_i) q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
            else       q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= 4'd0;
        else     q_q <= q_d;
    end

endmodule

// File: rtl/stopwatch_lap.sv
// Lap stopwatch: 7-digit BCD time with split hold, LAPN-deep lap FIFO
// (show-ahead head output) and, when STOPWATCH_LAP_TIMER_EN is defined,
// a count-down timer mode with clamped preset and zero alarm.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int MSPN = 5,
    parameter int MSPL = $clog2(MSPN),
    parameter int LAPN = 4,
    parameter int LAPL = $clog2(LAPN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          b_run,
    input  logic          b_clr,
    input  logic          b_lap,
    input  logic          mode,
    input  logic          preset_vld,
    input  logic [27:0]   preset,
    output logic [27:0]   t_bcd,
    output logic [27:0]   lap_bcd,
    output logic          lap_vld,
    output logic [LAPL:0] lap_cnt,
    output logic          lap_ovf,
    output logic          s_run,
    output logic          s_hld,
    output logic          alarm
);

    logic run_q, clr_q, lap_q;
    logic run_e, clr_e, lap_e;
    logic s_run_q, s_hld_q, mode_q, alarm_q;
    bcd_time_t hold_q, cnt, ld_val, cnt_start, preset_q, preset_cl;
    logic mode_eff, pv_eff, ld_en, start_ok, zero_hit, split, tick_en;
    logic [MSPL-1:0] div_q;
    logic tick_q;
    logic [DIGN:0] en_c;

    assign run_e = b_run & ~run_q;
    assign clr_e = b_clr & ~clr_q;
    assign lap_e = b_lap & ~lap_q;

    // Button edge-detect delay registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {run_q, clr_q, lap_q} <= 3'b000;
        else     {run_q, clr_q, lap_q} <= {b_run, b_clr, b_lap};
    end

`ifdef STOPWATCH_LAP_TIMER_EN
    assign mode_eff  = mode;
    assign pv_eff    = preset_vld;
    assign preset_cl = bcd_clamp(preset);

    // Preset register, only writable while stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    preset_q <= '0;
        else if (pv_eff && !s_run_q) preset_q <= preset_cl;
    end
`else
    logic unused_timer_in;
    assign unused_timer_in = ^{mode, preset_vld, preset};
    assign mode_eff  = 1'b0;
    assign pv_eff    = 1'b0;
    assign preset_cl = '0;
    assign preset_q  = '0;
`endif

    // Millisecond tick divider; the tick is registered one cycle after terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= s_run_q && (div_q == MSPL'(MSPN - 1));
            div_q  <= (!s_run_q || div_q == MSPL'(MSPN - 1)) ? '0 : div_q + MSPL'(1);
        end
    end

    assign tick_en = tick_q & s_run_q;
    assign en_c[0] = tick_en;

    // Loads happen only while stopped; a fresh preset strobe in timer mode
    // takes precedence over a clear in the same cycle.
    assign ld_en  = ~s_run_q & (clr_e | (pv_eff & mode_eff));
    assign ld_val = (pv_eff && mode_eff) ? preset_cl : (mode_eff ? preset_q : '0);

    // A start sees the count as it will be after any same-cycle load.
    assign cnt_start = ld_en ? ld_val : cnt;
    assign start_ok  = run_e & ~s_run_q & ~(mode_eff & (cnt_start == '0));
    assign zero_hit  = tick_en & mode_q & (cnt == bcd_time_t'(1));
    assign split     = clr_e & s_run_q & ~s_hld_q;

    for (genvar gi = 0; gi < DIGN; gi++) begin : g_dig
        bcd_digit #(.MAX(DIG_MAX[gi])) u_dig (
            .clk      (clk),
            .rst      (rst),
            .en_i     (en_c[gi]),
            .dir_i    (mode_q),
            .load_i   (ld_en),
            .ld_val_i (ld_val[gi]),
            .q_o      (cnt[gi]),
            .co_o     (en_c[gi+1])
        );
    end

    logic unused_top_carry;
    assign unused_top_carry = en_c[DIGN];

    // Run/stop, hold and alarm control; clear decisions use pre-edge s_run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_run_q <= 1'b0;
            s_hld_q <= 1'b0;
            mode_q  <= 1'b0;
            alarm_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            alarm_q <= zero_hit;
            if (zero_hit || (run_e && s_run_q)) s_run_q <= 1'b0;
            else if (start_ok)                  s_run_q <= 1'b1;
            if (start_ok) mode_q <= mode_eff;
            if (clr_e)    s_hld_q <= s_run_q & ~s_hld_q;
            if (split)    hold_q <= cnt;
        end
    end

    bcd_time_t mem_q [LAPN];
    logic [LAPL:0] wp_q, rp_q;
    logic lap_ovf_q, fifo_full, fifo_empty, pop, push_ok, flush;

    assign lap_cnt    = wp_q - rp_q;
    assign fifo_empty = (wp_q == rp_q);
    assign fifo_full  = (lap_cnt == (LAPL+1)'(LAPN));
    assign pop        = lap_e & ~fifo_empty;
    assign flush      = clr_e & ~s_run_q;
    assign push_ok    = split & (~fifo_full | pop);

    // FIFO pointers and sticky overflow; a stopped clear empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q      <= '0;
            rp_q      <= '0;
            lap_ovf_q <= 1'b0;
        end else if (flush) begin
            wp_q      <= '0;
            rp_q      <= '0;
            lap_ovf_q <= 1'b0;
        end else begin
            if (pop)                        rp_q <= rp_q + (LAPL+1)'(1);
            if (push_ok)                    wp_q <= wp_q + (LAPL+1)'(1);
            if (split && fifo_full && !pop) lap_ovf_q <= 1'b1;
        end
    end

    // Lap storage; contents are only observable through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q[LAPL-1:0]] <= cnt;
    end

    assign t_bcd   = s_hld_q ? hold_q : cnt;
    assign lap_bcd = fifo_empty ? '0 : mem_q[rp_q[LAPL-1:0]];
    assign lap_vld = ~fifo_empty;
    assign lap_ovf = lap_ovf_q;
    assign s_run   = s_run_q;
    assign s_hld   = s_hld_q;
    assign alarm   = alarm_q;

endmodule
